// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, start/done handshake.
// Optional signed-overflow output ovf is built when SIGNED_OVF_EN is defined.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int P  = WIDTH / DIGIT;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] ra, rb, res, res_nx;
    logic [CW-1:0]    cnt;
    logic             carry, last, load;
    logic [DIGIT:0]   sum;
`ifdef SIGNED_OVF_EN
    logic             sa, sb;
`endif

    always_comb begin
        sum      = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        res_nx   = WIDTH'({sum[DIGIT-1:0], res} >> DIGIT);
        last     = cnt == CW'(P - 1);
        load     = start && state != RUN;
        state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
        busy     = state == RUN;
        done     = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
`ifdef SIGNED_OVF_EN
            sa    <= 1'b0;
            sb    <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (load) begin
                ra    <= a;
                rb    <= b;
                carry <= c0;
                cnt   <= '0;
`ifdef SIGNED_OVF_EN
                sa    <= a[WIDTH-1];
                sb    <= b[WIDTH-1];
`endif
            end else if (state == RUN) begin
                ra    <= ra >> DIGIT;
                rb    <= rb >> DIGIT;
                carry <= sum[DIGIT];
                res   <= res_nx;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    s <= res_nx;
                    c <= sum[DIGIT];
`ifdef SIGNED_OVF_EN
                    // operand sign bits were shifted out, so the captured copies are used
                    ovf <= (sa ~^ sb) & (res_nx[WIDTH-1] != sa);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: checks DIGIT=4, 1 and 16 instances side by side against plain a+b+c0 arithmetic.
module tb_digit_serial_adder;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, c0 = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy_v[3], done_v[3], c_v[3];
    logic [15:0] s_v[3];
`ifdef SIGNED_OVF_EN
    logic        ovf_v[3];
`endif
    int          checks = 0, errors = 0;
    int          pv[3] = '{4, 16, 1};

    typedef struct {
        logic [15:0] a, b;
        logic        c0;
        logic [15:0] s;
        logic        c;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        digit_serial_adder #(.WIDTH(16), .DIGIT(g == 0 ? 4 : (g == 1 ? 1 : 16))) u_dut (
            .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c0(c0),
            .busy(busy_v[g]), .done(done_v[g]), .s(s_v[g]), .c(c_v[g])
`ifdef SIGNED_OVF_EN
            , .ovf(ovf_v[g])
`endif
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Start one operation and watch all three instances until they are idle again.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc0,
                          input logic [15:0] es, input logic ec);
        int lat[3], nd[3], nb[3];
        logic [15:0] gs[3];
        logic gc[3], go[3];
        a = ta; b = tb_; c0 = tc0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0; nd[i] = 0; nb[i] = busy_v[i] ? 1 : 0; gs[i] = 'x; gc[i] = 1'bx; go[i] = 1'bx;
        end
        for (int t = 1; t <= 18; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) nb[i]++;
                if (done_v[i]) begin
                    nd[i]++; lat[i] = t; gs[i] = s_v[i]; gc[i] = c_v[i];
`ifdef SIGNED_OVF_EN
                    go[i] = ovf_v[i];
`endif
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency[%0d] %h+%h+%0d", i, ta, tb_, tc0), lat[i], pv[i]);
            chk($sformatf("done_count[%0d]", i), nd[i], 1);
            chk($sformatf("busy_cycles[%0d]", i), nb[i], pv[i]);
            chk($sformatf("s[%0d] %h+%h+%0d", i, ta, tb_, tc0), gs[i], es);
            chk($sformatf("c[%0d] %h+%h+%0d", i, ta, tb_, tc0), gc[i], ec);
            chk($sformatf("s_hold[%0d]", i), s_v[i], es);
`ifdef SIGNED_OVF_EN
            chk($sformatf("ovf[%0d] %h+%h", i, ta, tb_), go[i],
                (ta[15] == tb_[15]) && (es[15] != ta[15]));
`endif
        end
    endtask

    initial begin
        int nd;
        int dt[$];
        logic [15:0] ds[$];
        logic [16:0] sum;
        logic [15:0] ra, rb;
        logic rc;
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[3] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        tbl[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1};
        tbl[6] = '{16'h0003, 16'hFFFE, 1'b0, 16'h0001, 1'b1};

        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_busy[%0d]", i), busy_v[i], 0);
            chk($sformatf("reset_done[%0d]", i), done_v[i], 0);
            chk($sformatf("reset_s[%0d]", i), s_v[i], 0);
            chk($sformatf("reset_c[%0d]", i), c_v[i], 0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[k]) run_op(tbl[k].a, tbl[k].b, tbl[k].c0, tbl[k].s, tbl[k].c);

        // start held high: mid-run start ignored, reload at the DONE edge
        a = 16'h0001; b = 16'h0001; c0 = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h00FF; b = 16'h0001;
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin dt.push_back(t); ds.push_back(s_v[0]); end
        end
        start = 1'b0;
        chk("b2b_done_count", dt.size(), 2);
        if (dt.size() >= 2) begin
            chk("b2b_first_time", dt[0], 4);
            chk("b2b_first_s", ds[0], 16'h0002);
            chk("b2b_second_time", dt[1], 9);
            chk("b2b_second_s", ds[1], 16'h0100);
        end
        repeat (20) @(posedge clk);
        #1;

        // asynchronous reset in the second RUN cycle
        a = 16'h1234; b = 16'h4321; c0 = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("rst_mid_busy", busy_v[0], 0);
        chk("rst_mid_done", done_v[0], 0);
        chk("rst_mid_s", s_v[0], 0);
        chk("rst_mid_c", c_v[0], 0);
        #1 rst = 1'b0;
        nd = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (done_v[0]) nd++;
        end
        chk("rst_mid_no_done", nd, 0);
        run_op(16'h000A, 16'h0005, 1'b0, 16'h000F, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            sum = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            run_op(ra, rb, rc, sum[15:0], sum[16]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through one DIGIT-wide adder slice with a registered carry. It is the sequential, generalised successor to the team's single-bit full adder. It serves area-constrained datapaths that can trade latency for adder width. It uses a start/done handshake toward a controlling FSM.

Parameters:
WIDTH, 16, operand and sum width in bits; must be an integer multiple of DIGIT
DIGIT, 4, bits added per cycle; 1 <= DIGIT <= WIDTH
P (localparam), WIDTH/DIGIT, number of compute cycles per operation

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled at rising clk edges
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
c0  input  1  carry-in; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: s/c valid
s  output  WIDTH  sum, registered
c  output  1  carry-out, registered
ovf  output  1  signed overflow; present only with SIGNED_OVF_EN

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, s=0, c=0, ovf=0. Internal operand/shift registers, digit counter and carry register are cleared.
- Reset mid-operation aborts immediately. No done pulse follows. s and c read 0.
- States: IDLE, RUN, DONE.
- IDLE: when start=1 at an edge, latch a, b and c0 into the carry register. Clear the counter to 0. Go to RUN. Otherwise stay in IDLE.
- RUN (busy=1): each edge computes {carry, digit} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry, using DIGIT+1-bit arithmetic.
  - Shift A and B right by DIGIT.
  - Shift the digit into the top of the result shift register; the result shifts right.
  - Increment the counter.
  - On the edge where the counter reaches P-1: copy the completed result to s and the final carry to c, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - If start=1 at this edge: a new operation loads and the state goes to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: start sampled at edge k; done is high in the cycle following edge k+P. Throughput is one result per P+1 cycles.
- start while busy=1 is ignored. Captured operands are not disturbed.
- a, b and c0 may change freely after the capturing edge.
- s, c and ovf change only on the completion edge. They hold their values through IDLE and through a subsequent RUN until the next completion.
- Arithmetic: {c,s} = a + b + c0, modulo 2^(WIDTH+1).
- Boundary cases:
  - DIGIT=WIDTH gives P=1: one RUN cycle.
  - DIGIT=1 gives a bit-serial full adder, P=WIDTH.

Optional Feature:
Macro SIGNED_OVF_EN.
- Defined: the ovf port exists. On the completion edge, ovf = a[WIDTH-1] XNOR b[WIDTH-1], AND s[WIDTH-1] != a[WIDTH-1]. The sign bits used are those of the captured operands. ovf resets to 0 and holds with s.
- Undefined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
Defaults WIDTH=16, DIGIT=4 unless stated.
- Basic add: start with a=16'h1234, b=16'h4321, c0=0 -> done pulses 5 cycles after the start edge, one cycle wide; s=16'h5555, c=0; busy high for 4 cycles.
- Carry ripple: a=16'hFFFF, b=16'h0001, c0=0 -> s=16'h0000, c=1. Then a=16'hFFFF, b=16'hFFFF, c0=1 -> s=16'hFFFF, c=1.
- Handshake:
  - Assert start=1 continuously with a=16'h0001, b=16'h0001, c0=0. Change operands to 16'h00FF/16'h0001 at the start of busy.
  - Expected: the first result is s=16'h0002. The mid-run start is ignored.
  - The second operation loads at the DONE edge and yields s=16'h0100, with done pulses spaced 5 cycles apart.
- Reset mid-op:
  - Assert rst asynchronously (between edges) in the 2nd RUN cycle.
  - Expected: busy, done, s and c go to 0 immediately, with no done pulse afterward.
  - The next start with a=16'h000A, b=16'h0005 gives s=16'h000F.
- Parameter sweep:
  - DIGIT=1: a=16'hAAAA, b=16'h5555, c0=1 -> s=16'h0000, c=1, done 17 cycles after start.
  - DIGIT=16: same result, done 2 cycles after start.
  - Random compare of {c,s} against a+b+c0 for 1000 vectors in each configuration.
- SIGNED_OVF_EN build: a=16'h7FFF, b=16'h0001 -> ovf=1. a=16'h8000, b=16'hFFFF -> ovf=1, c=1. a=16'h0003, b=16'hFFFE -> ovf=0, s=16'h0001.
